// File: rtl/quet_led_7doan_if.sv
// Display-stage bus: upstream count in, 7-segment drive and wrap pulse out.
interface quet_led_7doan_if;
    logic [3:0] q;
    logic [6:0] seg;
    logic [1:0] an;
    logic       wrap;

    modport master (output q, input seg, input an, input wrap);
    modport slave  (input q, output seg, output an, output wrap);
endinterface

// File: rtl/quet_led_7doan.sv
// Two-digit common-anode 7-segment multiplexer for a 0-15 count, with slot blanking and wrap detect.
// Optional: define LEADING_ZERO_BLANK_EN to blank the tens slot when the tens digit is 0.
module quet_led_7doan #(
    parameter int unsigned REFRESH_DIV = 4,
    parameter int unsigned BLANK_CYC   = 1
) (
    input  logic              clk,
    input  logic              reset,
    quet_led_7doan_if.slave   bus
);

    localparam int unsigned KW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [KW-1:0] K_LAST  = KW'(REFRESH_DIV - 1);
    localparam logic [KW-1:0] K_BLANK = KW'(BLANK_CYC);

    typedef enum logic {S_ONES, S_TENS} state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [3:0]    qr_q, qp_q;
    logic [3:0]    ones_q, ones_d;
    logic          tens_q, tens_d;
    logic [3:0]    split_ones;
    logic          split_tens;
    logic [6:0]    seg_q, seg_d;
    logic [1:0]    an_q, an_d;
    logic          wrap_q, wrap_d;

    function automatic logic [6:0] font(input logic [3:0] d);
        case (d)
            4'd0:    font = 7'b1000000;
            4'd1:    font = 7'b1111001;
            4'd2:    font = 7'b0100100;
            4'd3:    font = 7'b0110000;
            4'd4:    font = 7'b0011001;
            4'd5:    font = 7'b0010010;
            4'd6:    font = 7'b0000010;
            4'd7:    font = 7'b1111000;
            4'd8:    font = 7'b0000000;
            4'd9:    font = 7'b0010000;
            default: font = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        if (qr_q >= 4'd10) begin
            split_tens = 1'b1;
            split_ones = qr_q - 4'd10;
        end else begin
            split_tens = 1'b0;
            split_ones = qr_q;
        end
    end

    // Outputs are computed from the next state so the registered drive matches state/k after each edge.
    always_comb begin
        state_d = state_q;
        k_d     = k_q + KW'(1);
        ones_d  = ones_q;
        tens_d  = tens_q;
        if (k_q == K_LAST) begin
            k_d     = '0;
            state_d = (state_q == S_ONES) ? S_TENS : S_ONES;
            ones_d  = split_ones;
            tens_d  = split_tens;
        end

        an_d  = 2'b11;
        seg_d = '1;
        if (k_d >= K_BLANK) begin
            if (state_d == S_ONES) begin
                an_d  = 2'b10;
                seg_d = font(ones_d);
            end else begin
`ifdef LEADING_ZERO_BLANK_EN
                if (tens_d) begin
                    an_d  = 2'b01;
                    seg_d = font({3'b000, tens_d});
                end
`else
                an_d  = 2'b01;
                seg_d = font({3'b000, tens_d});
`endif
            end
        end

        wrap_d = (qp_q == 4'd15) && (qr_q == 4'd0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_ONES;
            k_q     <= '0;
            qr_q    <= '0;
            qp_q    <= '0;
            ones_q  <= '0;
            tens_q  <= 1'b0;
            an_q    <= 2'b11;
            seg_q   <= '1;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            qr_q    <= bus.q;
            qp_q    <= qr_q;
            ones_q  <= ones_d;
            tens_q  <= tens_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.an   = an_q;
    assign bus.seg  = seg_q;
    assign bus.wrap = wrap_q;

endmodule
